// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//   Emulates the bus side of an HD44780-style character LCD controller.
//   Bus transactions (rs/rw/data qualified by enable) commit on the falling
//   edge of enable. Instructions update the DDRAM address, entry mode and
//   display flags. Data writes fill a 32-byte DDRAM, or a 64-byte CGRAM when
//   that store is built. A busy down-counter emulates instruction execution
//   time. Reads drive either the busy/address byte or a RAM byte onto data_out.
//
//   Build option: define LCD_RX_CGRAM_EN to build the 64x8 CGRAM. Without it,
//   CGRAM writes only step cg_addr and CGRAM reads return 0x00.
//
// Ports
//   clk        in   clock, all state changes on its rising edge
//   reset      in   synchronous reset, active low
//   rs         in   register select (0 instruction, 1 data)
//   rw         in   0 write, 1 read
//   enable     in   bus strobe; transaction commits on its falling edge
//   data [7:0] in   write bus
//   data_out   out  read-back bus, valid while data_oe is high
//   data_oe    out  read-back enable
//   rd_idx     in   display-side DDRAM index {line, column[3:0]}
//   rd_char    out  DDRAM byte at rd_idx, one clock of latency
//   disp_on / cursor_on / blink_on  out  display-control flags
//   busy       out  emulated busy flag
//   err        out  sticky: a write arrived while busy
//
// State table
//   S_INIT | first cycle after reset; the DDRAM fill has not started yet
//   S_FILL | writing 0x20 into the DDRAM, one byte per cycle, index 31 down to 0
//   S_IDLE | normal operation
module lcd_bus_receiver #(
  parameter int CLEAR_CYCLES = 82000,
  parameter int CMD_CYCLES   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       err
);

  localparam int MAX_CYC = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {S_INIT, S_FILL, S_IDLE} state_t;

  state_t           state, state_nxt;
  logic             fill_we;
  logic [4:0]       fill_idx;

  logic             en_q, rs_q, rw_q;
  logic [7:0]       data_q;
  logic             live_q;

  logic [4:0]       addr;
  logic [5:0]       cg_addr;
  logic             tgt_cg;
  logic             inc;
  logic [CNT_W-1:0] cnt;

  logic [7:0]       ddram [32];
  logic [7:0]       cg_byte;
  logic [7:0]       rd_byte;

  logic fall, wr_commit, wr_ok, wr_err, rd_commit;
  logic instr_ok, clear_go, dd_we, cg_we, step;

  // Bus capture: the last enable-high cycle holds the committed values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      en_q <= enable;
      if (enable) begin
        rs_q   <= rs;
        rw_q   <= rw;
        data_q <= data;
      end
    end
  end

  assign busy      = (cnt != '0) || (state == S_FILL);
  assign fall      = en_q & ~enable;
  assign wr_commit = fall & ~rw_q;
  assign wr_ok     = wr_commit & ~busy;
  assign wr_err    = wr_commit & busy;
  assign rd_commit = fall & rw_q;
  assign instr_ok  = wr_ok & ~rs_q;
  assign clear_go  = instr_ok & (data_q == 8'h01);
  assign dd_we     = wr_ok & rs_q & ~tgt_cg;
  assign cg_we     = wr_ok & rs_q & tgt_cg;
  assign step      = (wr_ok | rd_commit) & rs_q;

  // Fill sequencer
  always_ff @(posedge clk) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fill_we   = 1'b0;
    case (state)
      S_INIT: state_nxt = S_FILL;
      S_FILL: begin
        fill_we = 1'b1;
        if (fill_idx == 5'd0) state_nxt = S_IDLE;
      end
      S_IDLE: if (clear_go) state_nxt = S_FILL;
      default: state_nxt = S_INIT;
    endcase
  end

  // Fill index counts down and wraps 0 -> 31, so it is back at 31 when idle.
  always_ff @(posedge clk) begin
    if (!reset)        fill_idx <= 5'd31;
    else if (clear_go) fill_idx <= 5'd31;
    else if (fill_we)  fill_idx <= fill_idx - 5'd1;
  end

  // Control registers, instruction decode and busy timer
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr      <= 5'd0;
      cg_addr   <= 6'd0;
      tgt_cg    <= 1'b0;
      inc       <= 1'b1;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      live_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      if (wr_err)    err <= 1'b1;
      if (wr_ok)     cnt <= CNT_W'(CMD_CYCLES);
      // Decode on the highest set bit of the instruction byte.
      if (instr_ok) begin
        if (data_q[7]) begin
          tgt_cg <= 1'b0;
          addr   <= {data_q[6], data_q[3:0]};
        end else if (data_q[6]) begin
          tgt_cg  <= 1'b1;
          cg_addr <= data_q[5:0];
        end else if (data_q[5]) begin
          // function set: accepted, nothing to change
        end else if (data_q[4]) begin
          if (!data_q[3]) addr <= data_q[2] ? addr + 5'd1 : addr - 5'd1;
        end else if (data_q[3]) begin
          disp_on   <= data_q[2];
          cursor_on <= data_q[1];
          blink_on  <= data_q[0];
        end else if (data_q[2]) begin
          inc <= data_q[1];
        end else if (data_q[1]) begin
          addr <= 5'd0;
        end else if (data_q[0]) begin
          addr <= 5'd0;
          inc  <= 1'b1;
          cnt  <= CNT_W'(CLEAR_CYCLES);
        end
      end
      if (step) begin
        if (tgt_cg) cg_addr <= inc ? cg_addr + 6'd1 : cg_addr - 6'd1;
        else        addr    <= inc ? addr + 5'd1    : addr - 5'd1;
      end
    end
  end

  // DDRAM: the fill and a data write never coincide because the fill keeps busy high.
  always_ff @(posedge clk) begin
    if (fill_we)    ddram[fill_idx] <= 8'h20;
    else if (dd_we) ddram[addr]     <= data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) rd_char <= 8'h00;
    else        rd_char <= ddram[rd_idx];
  end

`ifdef LCD_RX_CGRAM_EN
  logic [7:0] cgram [64];

  always_ff @(posedge clk) begin
    if (cg_we) cgram[cg_addr] <= data_q;
  end

  assign cg_byte = cgram[cg_addr];
`else
  logic cg_we_unused;
  assign cg_we_unused = cg_we;
  assign cg_byte      = 8'h00;
`endif

  assign rd_byte = tgt_cg ? cg_byte : ddram[addr];

  // Read-back follows the live bus so it is valid for the whole enable-high phase.
  assign data_oe  = enable & rw & live_q;
  assign data_out = !data_oe ? 8'h00
                  : rs       ? rd_byte
                  :            {busy, addr[4], 2'b00, addr[3:0]};

endmodule

// File: tb/tb_lcd_bus_receiver.sv
module tb_lcd_bus_receiver;

  localparam int CLR = 200;
  localparam int CMD = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rs = 1'b0, rw = 1'b0, enable = 1'b0;
  logic [7:0] data = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] data_out, rd_char;
  logic       data_oe, disp_on, cursor_on, blink_on, busy, err;

  lcd_bus_receiver #(.CLEAR_CYCLES(CLR), .CMD_CYCLES(CMD)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data),
    .data_out(data_out), .data_oe(data_oe), .rd_idx(rd_idx), .rd_char(rd_char),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model: array contents, plain integer addresses, busy as an end cycle.
  logic [7:0] dd_m [32];
  logic [7:0] cg_m [64];
  bit         cg_v [64];
  int         addr_m = 0, cga_m = 0, busy_end = 0;
  bit         tgt_cg_m = 0, inc_m = 1, disp_m = 0, cur_m = 0, blk_m = 0, err_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy_m();
    return cyc < busy_end;
  endfunction

  task automatic step_m();
    if (tgt_cg_m) cga_m  = (cga_m  + (inc_m ? 1 : 63)) % 64;
    else          addr_m = (addr_m + (inc_m ? 1 : 31)) % 32;
  endtask

  task automatic model_cmd(input logic [7:0] d, input int c);
    int hb;
    hb = -1;
    for (int i = 0; i < 8; i++) if (d[i]) hb = i;
    case (hb)
      0: begin
        foreach (dd_m[j]) dd_m[j] = 8'h20;
        addr_m = 0; inc_m = 1; busy_end = c + CLR;
      end
      1: addr_m = 0;
      2: inc_m = d[1];
      3: begin disp_m = d[2]; cur_m = d[1]; blk_m = d[0]; end
      4: if (!d[3]) addr_m = (addr_m + (d[2] ? 1 : 31)) % 32;
      6: begin tgt_cg_m = 1; cga_m = int'(d[5:0]); end
      7: begin tgt_cg_m = 0; addr_m = (d[6] ? 16 : 0) + int'(d[3:0]); end
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    while (cyc < busy_end) @(negedge clk);
  endtask

  task automatic xact(input bit r_s, input bit r_w, input logic [7:0] d, input int hold);
    int c;
    logic [7:0] e;
    bit known;
    @(negedge clk);
    rs = r_s; rw = r_w; data = d; enable = 1'b1;
    repeat (hold) @(negedge clk);
    if (r_w) begin
      chk("data_oe_read", data_oe, 1);
      if (r_s) begin
        known = 1;
        if (tgt_cg_m) begin
`ifdef LCD_RX_CGRAM_EN
          e = cg_m[cga_m];
          known = cg_v[cga_m];
`else
          e = 8'h00;
`endif
        end else e = dd_m[addr_m];
        if (known) chk("data_read", data_out, e);
      end else begin
        e = {1'(busy_m()), 1'(addr_m / 16), 2'b00, 4'(addr_m % 16)};
        chk("busy_read", data_out, e);
      end
    end else chk("data_oe_write", data_oe, 0);
    enable = 1'b0;
    @(negedge clk);
    c = cyc;   // edge that committed the transaction
    if (!r_w) begin
      if (c - 1 < busy_end) err_m = 1;
      else begin
        busy_end = c + CMD;
        if (r_s) begin
          if (tgt_cg_m) begin cg_m[cga_m] = d; cg_v[cga_m] = 1; end
          else dd_m[addr_m] = d;
          step_m();
        end else model_cmd(d, c);
      end
    end else if (r_s) step_m();
    chk("data_oe_idle", data_oe, 0);
    chk("busy", busy, busy_m());
    chk("err", err, err_m);
    chk("flags", {disp_on, cursor_on, blink_on}, {disp_m, cur_m, blk_m});
  endtask

  task automatic scan_ddram();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_idx = 5'(i);
      @(negedge clk);
      chk("rd_char", rd_char, dd_m[i]);
    end
  endtask

  task automatic check_char(input int idx);
    @(negedge clk);
    rd_idx = 5'(idx);
    @(negedge clk);
    chk("rd_char_at", rd_char, dd_m[idx]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int k, hold;

    // Reset with a read strobe active: outputs must stay quiet.
    reset = 1'b0; enable = 1'b1; rw = 1'b1; rs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_char", rd_char, 8'h00);
    chk("rst_flags", {disp_on, cursor_on, blink_on}, 3'b000);
    // A write pending under reset must be dropped.
    rw = 1'b0; data = 8'h0F;
    @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    repeat (40) @(negedge clk);
    foreach (dd_m[j]) dd_m[j] = 8'h20;
    busy_end = 0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_flags", {disp_on, cursor_on, blink_on}, 3'b000);
    scan_ddram();

    // Display on, two characters, busy read shows address 2.
    xact(0, 0, 8'h0F, 1); wait_idle();
    xact(0, 0, 8'h80, 2); wait_idle();
    xact(1, 0, 8'h41, 1); wait_idle();
    xact(1, 0, 8'h42, 3); wait_idle();
    xact(0, 1, 8'h00, 2);
    chk("busy_read_addr2", {disp_on, cursor_on, blink_on}, 3'b111);
    check_char(0);
    check_char(1);

    // Last cell then wrap to 0; busy read immediately while still busy.
    wait_idle();
    xact(0, 0, 8'hCF, 1); wait_idle();
    xact(1, 0, 8'h5A, 1);
    xact(0, 1, 8'h00, 1);
    check_char(31);

    // Data write straight after a command: discarded, err set.
    wait_idle();
    xact(0, 0, 8'h80, 1);
    xact(1, 0, 8'h33, 1);
    chk("err_after_busy_write", err, 1);
    check_char(0);

    // Decrement mode: write at 0, address goes to 31.
    wait_idle();
    xact(0, 0, 8'h04, 1); wait_idle();
    xact(0, 0, 8'h80, 1); wait_idle();
    xact(1, 0, 8'h55, 1); wait_idle();
    xact(0, 1, 8'h00, 1);
    check_char(0);

    // CGRAM write and read-back.
    xact(0, 0, 8'h06, 1); wait_idle();
    xact(0, 0, 8'h40, 1); wait_idle();
    xact(1, 0, 8'h1F, 1); wait_idle();
    xact(0, 0, 8'h40, 1); wait_idle();
    xact(1, 1, 8'h00, 2);

    // Clear refills the DDRAM and homes the address.
    wait_idle();
    xact(0, 0, 8'h85, 1); wait_idle();
    xact(1, 0, 8'h77, 1); wait_idle();
    xact(0, 0, 8'h01, 1); wait_idle();
    xact(0, 1, 8'h00, 1);
    scan_ddram();

    // Randomized traffic, sometimes arriving while busy.
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 3);
      hold = $urandom_range(1, 3);
      if ($urandom_range(0, 3) != 0) wait_idle();
      d = 8'($urandom);
      case (k)
        0: begin
          if (d == 8'h01) d = 8'h02;
          xact(0, 0, d, hold);
        end
        1: xact(1, 0, d, hold);
        2: xact(0, 1, 8'h00, hold);
        default: xact(1, 1, 8'h00, hold);
      endcase
    end
    wait_idle();
    scan_ddram();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
